// File: rtl/bcd_seg_driver.sv
// bcd_seg_driver: sequential double-dabble BCD conversion feeding an active-low 7-segment digit mux.
// Build option SIGNED_DISPLAY_EN: two's-complement input, digit 3 shows the sign.
module bcd_seg_driver #(
    parameter int DATA_W   = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        sel,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] operand;
    logic [15:0]       bcd, bcd_adj, display;
    logic [CNT_W-1:0]  count;
    logic              last_shift;
    logic [3:0]        digit;
    logic              lz_blank;
    logic [6:0]        seg_next;

`ifdef SIGNED_DISPLAY_EN
    logic sign_in, neg_cap, neg_disp;

    // Most negative input negates to itself, which is its correct unsigned magnitude.
    assign sign_in = data_in[DATA_W-1];
    assign operand = sign_in ? (~data_in + DATA_W'(1)) : data_in;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            neg_cap  <= 1'b0;
            neg_disp <= 1'b0;
        end else begin
            if (state == IDLE && load) neg_cap <= sign_in;
            if (state == SHIFT && last_shift) neg_disp <= neg_cap;
        end
    end
`else
    assign operand = data_in;
`endif

    assign last_shift = (count == CNT_W'(DATA_W));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Display is loaded on the edge entering DONE so it is valid while done is high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shift   <= '0;
            bcd     <= '0;
            count   <= '0;
            display <= '0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    shift <= operand;
                    bcd   <= '0;
                    count <= '0;
                end
                SHIFT: if (!last_shift) begin
                    {bcd, shift} <= {bcd_adj, shift} << 1;
                    count        <= count + 1'b1;
                end else begin
                    display <= bcd;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'h40;
            4'd1:    enc7 = 7'h79;
            4'd2:    enc7 = 7'h24;
            4'd3:    enc7 = 7'h30;
            4'd4:    enc7 = 7'h19;
            4'd5:    enc7 = 7'h12;
            4'd6:    enc7 = 7'h02;
            4'd7:    enc7 = 7'h78;
            4'd8:    enc7 = 7'h00;
            4'd9:    enc7 = 7'h10;
            default: enc7 = 7'h7F;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        digit    = display[4*sel +: 4];
        lz_blank = BLANK_LZ && (sel != 2'd0) && ((display >> {sel, 2'b00}) == 16'd0);
        seg_next = lz_blank ? 7'h7F : enc7(digit);
`ifdef SIGNED_DISPLAY_EN
        if (sel == 2'd3) seg_next = neg_disp ? 7'h3F : 7'h7F;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) seg <= 7'h7F;
        else       seg <= seg_next;
    end

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Self-checking bench for bcd_seg_driver: directed scenarios plus randomized loads checked
// against an arithmetic digit model, with one instance per leading-zero blanking mode.
module tb_bcd_seg_driver;
    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    sel = 2'd0;
    logic [6:0]    seg, seg_nb;
    logic          busy, done, busy_nb, done_nb;

    int n_cmp = 0;
    int n_bad = 0;
    int disp_val = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pow10 [4] = '{1, 10, 100, 1000};

    always #5 Clk = ~Clk;

    bcd_seg_driver #(.DATA_W(DW), .BLANK_LZ(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .load(load), .data_in(data_in), .sel(sel),
        .seg(seg), .busy(busy), .done(done)
    );

    bcd_seg_driver #(.DATA_W(DW), .BLANK_LZ(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .load(load), .data_in(data_in), .sel(sel),
        .seg(seg_nb), .busy(busy_nb), .done(done_nb)
    );

    // Expected cathodes for digit s of the raw input pattern v.
    function automatic logic [6:0] model_seg(input int v, input int s, input bit blz);
        int mag;
        int top_digit;
`ifdef SIGNED_DISPLAY_EN
        bit neg;
        neg = ((v >> (DW - 1)) & 1) != 0;
        mag = neg ? ((1 << DW) - v) : v;
        if (s == 3) return neg ? 7'h3F : 7'h7F;
        top_digit = 2;
`else
        mag = v;
        top_digit = 3;
`endif
        if (s > top_digit) return 7'h7F;
        if (blz && s > 0 && mag < pow10[s]) return 7'h7F;
        return seg_tbl[(mag / pow10[s]) % 10];
    endfunction

    task automatic test_reset();
        Reset = 1'b1; load = 1'b0; data_in = '0; sel = 2'd0;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h exp 7f", seg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
        Reset = 1'b0;
        disp_val = 0;
        @(posedge Clk); #1;
        n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL reset_release_seg got %h exp 40", seg); end
        for (int s = 1; s < 4; s++) begin
            sel = 2'(s);
            @(posedge Clk); #1;
            n_cmp++; if (seg !== model_seg(0, s, 1'b1)) begin n_bad++; $display("FAIL reset_digit sel=%0d got %h exp %h", s, seg, model_seg(0, s, 1'b1)); end
            n_cmp++; if (seg_nb !== model_seg(0, s, 1'b0)) begin n_bad++; $display("FAIL reset_digit_nb sel=%0d got %h exp %h", s, seg_nb, model_seg(0, s, 1'b0)); end
        end
    endtask

    task automatic test_timing_255();
        logic [6:0] old_seg;
        sel = 2'd0;
        @(posedge Clk); #1;
        old_seg = model_seg(disp_val, 0, 1'b1);
        data_in = 8'd255; load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t255_busy_edge0 got %b exp 1", busy); end
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t255_early_done edge=%0d got %b exp 0", i, done); end
            n_cmp++; if (seg !== old_seg) begin n_bad++; $display("FAIL t255_seg_hold edge=%0d got %h exp %h", i, seg, old_seg); end
        end
        @(posedge Clk); #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL t255_done_edge9 got %b exp 1", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t255_busy_edge9 got %b exp 1", busy); end
        @(posedge Clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t255_done_edge10 got %b exp 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t255_busy_edge10 got %b exp 0", busy); end
        disp_val = 255;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            @(posedge Clk); #1;
            n_cmp++; if (seg !== model_seg(disp_val, s, 1'b1)) begin n_bad++; $display("FAIL t255_digit sel=%0d got %h exp %h", s, seg, model_seg(disp_val, s, 1'b1)); end
            n_cmp++; if (seg_nb !== model_seg(disp_val, s, 1'b0)) begin n_bad++; $display("FAIL t255_digit_nb sel=%0d got %h exp %h", s, seg_nb, model_seg(disp_val, s, 1'b0)); end
        end
    endtask

    task automatic test_embedded_zero();
        bit seen;
        seen = 1'b0;
        data_in = 8'd100; load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge Clk); #1;
            if (done) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL ez_done_timeout got none exp pulse"); end
        disp_val = 100;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            @(posedge Clk); #1;
            n_cmp++; if (seg !== model_seg(disp_val, s, 1'b1)) begin n_bad++; $display("FAIL ez_digit sel=%0d got %h exp %h", s, seg, model_seg(disp_val, s, 1'b1)); end
            n_cmp++; if (seg_nb !== model_seg(disp_val, s, 1'b0)) begin n_bad++; $display("FAIL ez_digit_nb sel=%0d got %h exp %h", s, seg_nb, model_seg(disp_val, s, 1'b0)); end
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        int de;
        nd = 0; de = -1;
        data_in = 8'd255; load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3 || i == 10) begin load = 1'b1; data_in = 8'd7; end
            if (i == 4 || i == 11) load = 1'b0;
            @(posedge Clk); #1;
            if (done) begin nd++; de = i; end
        end
        n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL b2b_done_count got %0d exp 1", nd); end
        n_cmp++; if (de != 9) begin n_bad++; $display("FAIL b2b_done_edge got %0d exp 9", de); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after got %b exp 0", busy); end
        disp_val = 255;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            @(posedge Clk); #1;
            n_cmp++; if (seg !== model_seg(disp_val, s, 1'b1)) begin n_bad++; $display("FAIL b2b_digit sel=%0d got %h exp %h", s, seg, model_seg(disp_val, s, 1'b1)); end
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        data_in = 8'd200; load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b exp 0", busy); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL rmid_seg got %h exp 7f", seg); end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        disp_val = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (done) nd++;
        end
        n_cmp++; if (nd != 0) begin n_bad++; $display("FAIL rmid_done_count got %0d exp 0", nd); end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            @(posedge Clk); #1;
            n_cmp++; if (seg !== model_seg(disp_val, s, 1'b1)) begin n_bad++; $display("FAIL rmid_digit sel=%0d got %h exp %h", s, seg, model_seg(disp_val, s, 1'b1)); end
            n_cmp++; if (seg_nb !== model_seg(disp_val, s, 1'b0)) begin n_bad++; $display("FAIL rmid_digit_nb sel=%0d got %h exp %h", s, seg_nb, model_seg(disp_val, s, 1'b0)); end
        end
    endtask

    task automatic test_random();
        int v;
        int de;
        for (int n = 0; n < 20; n++) begin
            if (n == 0)      v = 128;
            else if (n == 1) v = 0;
            else if (n == 2) v = 246;
            else             v = int'($urandom_range(0, 255));
            de = -1;
            data_in = DW'(v); load = 1'b1;
            @(posedge Clk); #1;
            load = 1'b0;
            for (int i = 1; i <= 12; i++) begin
                @(posedge Clk); #1;
                if (done && de < 0) de = i;
            end
            n_cmp++; if (de != 9) begin n_bad++; $display("FAIL rand_done_edge v=%0d got %0d exp 9", v, de); end
            disp_val = v;
            for (int s = 0; s < 4; s++) begin
                sel = 2'(s);
                @(posedge Clk); #1;
                n_cmp++; if (seg !== model_seg(disp_val, s, 1'b1)) begin n_bad++; $display("FAIL rand_digit v=%0d sel=%0d got %h exp %h", v, s, seg, model_seg(disp_val, s, 1'b1)); end
                n_cmp++; if (seg_nb !== model_seg(disp_val, s, 1'b0)) begin n_bad++; $display("FAIL rand_digit_nb v=%0d sel=%0d got %h exp %h", v, s, seg_nb, model_seg(disp_val, s, 1'b0)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing_255();
        test_embedded_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
